hazard_stall_ctrl: RTL
======================

// Module: hazard_stall_ctrl
// PURPOSE
//  Central pipeline sequencer for the 5-stage RV32 core. It drives the hold and clear controls of
//  PC, IF/ID, ID/EX and EX/MEM, including id_reg_clr on Reg_ID_EX. It resolves three hazards:
//  load-use, taken branch/jump redirect, and data-memory wait states. It also keeps a stall
//  counter and a memory-timeout error.
// PARAMETERS
//  TIMEOUT_W  4   width of the mem-wait counter; timeout after 2**TIMEOUT_W-1 consecutive wait cycles
//  CNT_W      32  width of the stall performance counter
// PORTS
//  clk            in   1         clock; all state updates on posedge
//  rst            in   1         synchronous, active-high reset
//  id_rs1         in   5         rs1 of the instruction in ID
//  id_rs2         in   5         rs2 of the instruction in ID
//  id_use_rs1     in   1         ID instruction reads rs1
//  id_use_rs2     in   1         ID instruction reads rs2
//  ex_rd          in   5         rd of the instruction in EX
//  ex_RegWEn      in   1         EX instruction writes rd
//  ex_is_load     in   1         EX instruction is a load (WBSel = mem)
//  ex_redirect    in   1         EX resolved a taken branch or a jal/jalr
//  mem_req        in   1         MEM stage has an active data-memory access
//  mem_ready      in   1         data memory completes the access this cycle
//  pc_stall       out  1         hold PC
//  if_id_stall    out  1         hold IF/ID
//  if_id_clr      out  1         load NOP into IF/ID
//  id_reg_clr     out  1         load bubble into ID/EX (to Reg_ID_EX)
//  id_ex_stall    out  1         hold ID/EX
//  ex_mem_stall   out  1         hold EX/MEM
//  mem_wb_bubble  out  1         MEM/WB captures a bubble (RegWEn=0)
//  stall_cnt      out  CNT_W     cycles with pc_stall=1; saturates at all-ones
//  mem_timeout    out  1         sticky error flag
// BEHAVIOUR
//  Clock and reset
//  - One clock. Reset is synchronous and active-high.
//  - Cycle with rst=1: every control output reads 0 and the FSM state is ignored.
//  - Next edge after rst=1: state=RUN, wait_cnt=0, stall_cnt=0, mem_timeout=0.
//  Control outputs
//  - Control outputs are combinational from the registered state and the current inputs; 0-cycle latency.
//  Hazard terms
//  - memw = mem_req & ~mem_ready
//  - lu   = ex_is_load & ex_RegWEn & (ex_rd!=0) & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd))
//  Priority, first match wins
//  - 1) memw: pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_bubble = 1; all clears = 0.
//    The redirect and load-use are deferred; inputs stay stable because EX is frozen.
//  - 2) ex_redirect: if_id_clr=1, id_reg_clr=1, no stalls.
//  - 3) state==BR_FLUSH: if_id_clr=1. This kills the wrong-path fetch from the 1-cycle-latency IMEM.
//  - 4) lu: pc_stall=1, if_id_stall=1, id_reg_clr=1. This gives exactly one bubble; the next cycle
//    the load is in MEM and the match clears.
//  FSM (RUN, MEM_WAIT, BR_FLUSH)
//  - RUN      -> MEM_WAIT if memw
//  - RUN      -> BR_FLUSH if ex_redirect & ~memw
//  - RUN      -> RUN otherwise
//  - MEM_WAIT -> MEM_WAIT while memw
//  - MEM_WAIT -> BR_FLUSH on ~memw & ex_redirect
//  - MEM_WAIT -> RUN on ~memw & ~ex_redirect
//  - BR_FLUSH -> MEM_WAIT if memw
//  - BR_FLUSH -> BR_FLUSH if ex_redirect (back-to-back redirect)
//  - BR_FLUSH -> RUN otherwise
//  Wait counter and timeout
//  - wait_cnt (TIMEOUT_W bits) increments each cycle with state==MEM_WAIT & memw.
//  - wait_cnt clears on leaving MEM_WAIT.
//  - When wait_cnt reaches all-ones, mem_timeout sets and stays set until rst. Stalling continues.
//  Stall counter
//  - stall_cnt += 1 on every cycle with pc_stall=1; it saturates.
//  Boundary cases
//  - mem_ready and mem_req rising in the same cycle: no stall; a zero-wait access never enters MEM_WAIT.
//  - ex_rd==0 never triggers a load-use stall.
//  - rst asserted mid-MEM_WAIT: next cycle is RUN with counters and timeout cleared.
// TESTING
//  - lw x5 in EX, add x6,x5,x1 in ID -> one cycle: pc_stall=1, if_id_stall=1, id_reg_clr=1;
//    next cycle all 0; stall_cnt=1.
//  - ex_redirect=1 for 1 cycle -> that cycle if_id_clr=1 and id_reg_clr=1; next cycle
//    (BR_FLUSH) if_id_clr=1 only; then RUN.
//  - mem_req=1, mem_ready=0 for 3 cycles then 1 -> 3 cycles of all stalls and mem_wb_bubble;
//    4th cycle released; stall_cnt=3.
//  - memw together with ex_redirect -> stalls only while waiting; on mem_ready, if_id_clr
//    and id_reg_clr fire, then BR_FLUSH.
//  - mem_ready held 0 for 16 cycles (TIMEOUT_W=4) -> mem_timeout=1 after 15 wait cycles;
//    stays 1 after release; clears only on rst.
//  - rst pulsed during MEM_WAIT -> next cycle state RUN, stall_cnt=0, mem_timeout=0,
//    all controls 0 when mem_req=0.

Source files
------------

// File: rtl/hazard_stall_ctrl_if.sv
// Hazard/stall control bundle between the 5-stage pipeline datapath and its sequencer.
// The master side is the pipeline; the slave side is hazard_stall_ctrl.
interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rd;
    logic             ex_RegWEn;
    logic             ex_is_load;
    logic             ex_redirect;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_stall;
    logic             if_id_stall;
    logic             if_id_clr;
    logic             id_reg_clr;
    logic             id_ex_stall;
    logic             ex_mem_stall;
    logic             mem_wb_bubble;
    logic [CNT_W-1:0] stall_cnt;
    logic             mem_timeout;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_RegWEn, ex_is_load,
               ex_redirect, mem_req, mem_ready,
        input  pc_stall, if_id_stall, if_id_clr, id_reg_clr, id_ex_stall, ex_mem_stall,
               mem_wb_bubble, stall_cnt, mem_timeout
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_RegWEn, ex_is_load,
               ex_redirect, mem_req, mem_ready,
        output pc_stall, if_id_stall, if_id_clr, id_reg_clr, id_ex_stall, ex_mem_stall,
               mem_wb_bubble, stall_cnt, mem_timeout
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer for the 5-stage RV32 core: load-use, redirect and memory-wait hazards,
// plus a saturating stall counter and a sticky memory-timeout flag.
module hazard_stall_ctrl #(
    parameter int TIMEOUT_W = 4,
    parameter int CNT_W     = 32
) (
    input logic              clk,
    input logic              rst,
    hazard_stall_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        BR_FLUSH = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic [TIMEOUT_W-1:0] wait_inc;
    logic [CNT_W-1:0]     stall_cnt_q;
    logic                 mem_timeout_q;
    logic                 memw;
    logic                 lu;
    logic                 rs1_hit;
    logic                 rs2_hit;

    logic pc_stall_c, if_id_stall_c, if_id_clr_c, id_reg_clr_c;
    logic id_ex_stall_c, ex_mem_stall_c, mem_wb_bubble_c;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [TIMEOUT_W-1:0] sat_inc_wait(input logic [TIMEOUT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign memw    = bus.mem_req & ~bus.mem_ready;
    assign rs1_hit = bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd);
    assign rs2_hit = bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd);
    assign lu      = bus.ex_is_load & bus.ex_RegWEn & (bus.ex_rd != 5'd0) & (rs1_hit | rs2_hit);
    assign wait_inc = sat_inc_wait(wait_cnt);

    // Control decode: first matching hazard wins; a frozen EX keeps deferred hazards stable.
    always_comb begin
        pc_stall_c      = 1'b0;
        if_id_stall_c   = 1'b0;
        if_id_clr_c     = 1'b0;
        id_reg_clr_c    = 1'b0;
        id_ex_stall_c   = 1'b0;
        ex_mem_stall_c  = 1'b0;
        mem_wb_bubble_c = 1'b0;
        state_nxt       = state;

        if (rst) begin
            state_nxt = RUN;
        end else begin
            if (memw) begin
                pc_stall_c      = 1'b1;
                if_id_stall_c   = 1'b1;
                id_ex_stall_c   = 1'b1;
                ex_mem_stall_c  = 1'b1;
                mem_wb_bubble_c = 1'b1;
            end else if (bus.ex_redirect) begin
                if_id_clr_c  = 1'b1;
                id_reg_clr_c = 1'b1;
            end else if (state == BR_FLUSH) begin
                if_id_clr_c = 1'b1;
            end else if (lu) begin
                pc_stall_c    = 1'b1;
                if_id_stall_c = 1'b1;
                id_reg_clr_c  = 1'b1;
            end

            case (state)
                RUN, MEM_WAIT, BR_FLUSH: begin
                    if (memw)                 state_nxt = MEM_WAIT;
                    else if (bus.ex_redirect) state_nxt = BR_FLUSH;
                    else                      state_nxt = RUN;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // State, wait counter, timeout and stall counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            wait_cnt      <= '0;
            stall_cnt_q   <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == MEM_WAIT && memw) begin
                wait_cnt <= wait_inc;
                if (&wait_inc) mem_timeout_q <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (pc_stall_c) stall_cnt_q <= sat_inc_cnt(stall_cnt_q);
        end
    end

    assign bus.pc_stall      = pc_stall_c;
    assign bus.if_id_stall   = if_id_stall_c;
    assign bus.if_id_clr     = if_id_clr_c;
    assign bus.id_reg_clr    = id_reg_clr_c;
    assign bus.id_ex_stall   = id_ex_stall_c;
    assign bus.ex_mem_stall  = ex_mem_stall_c;
    assign bus.mem_wb_bubble = mem_wb_bubble_c;
    assign bus.stall_cnt     = stall_cnt_q;
    assign bus.mem_timeout   = mem_timeout_q;
endmodule
